// File: rtl/condicionador_botao_pkg.sv
// Shared definitions for the pedestrian button conditioner: FSM encoding
// (common with the semaforo controller) and default timing parameters.
package condicionador_botao_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    PENDENTE = 2'd1,
    BLOQUEIO = 2'd2,
    INVALIDO = 2'd3
  } estado_t;

  localparam logic [7:0] DEB_CYCLES_PADRAO = 8'd3;
  localparam logic [7:0] HOLDOFF_PADRAO    = 8'd4;

endpackage

// File: rtl/debounce_sinal.sv
// Two-flop synchroniser followed by a stability-counter debounce.
// subida flags the cycle whose update takes the debounced level d from 0 to 1.
module debounce_sinal
  import condicionador_botao_pkg::*;
#(
  parameter logic [7:0] DEB_CYCLES = DEB_CYCLES_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic bt_bruto,
  output logic d,
  output logic subida
);

  logic       sync_p0;
  logic       sync_p1;
  logic [7:0] cnt;
  logic       muda;

  // One count short of DEB_CYCLES plus a differing sample flips d this edge.
  assign muda   = (sync_p1 != d) && ((cnt + 8'd1) == DEB_CYCLES);
  assign subida = muda && sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      d       <= 1'b0;
      cnt     <= 8'd0;
    end else begin
      // stage p0/p1: metastability filter
      sync_p0 <= bt_bruto;
      sync_p1 <= sync_p0;
      // stage p2: stability counter
      if (sync_p1 == d) begin
        cnt <= 8'd0;
      end else if (muda) begin
        d   <= sync_p1;
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/condicionador_botao.sv
// Pedestrian button conditioner: debounced rise -> one latched request with a
// single-cycle bt pulse, held until atende, followed by a hold-off window.
module condicionador_botao
  import condicionador_botao_pkg::*;
#(
  parameter logic [7:0] DEB_CYCLES = DEB_CYCLES_PADRAO,
  parameter logic [7:0] HOLDOFF    = HOLDOFF_PADRAO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt_bruto,
  input  logic       atende,
  output logic       bt,
  output logic       pendente,
  output logic       bloqueado,
  output logic [1:0] estado
);

  logic       nivel;
  logic       subida;
  estado_t    est_p2;
  estado_t    est_n;
  logic [7:0] hcnt_p2;
  logic [7:0] hcnt_n;
  logic       bt_n;

  debounce_sinal #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .bt_bruto(bt_bruto),
    .d       (nivel),
    .subida  (subida)
  );

  always_comb begin
    est_n  = est_p2;
    hcnt_n = hcnt_p2;
    bt_n   = 1'b0;
    case (est_p2)
      OCIOSO: begin
        // a rise is only genuine while the debounced level is still low
        if (subida && !nivel) begin
          est_n = PENDENTE;
          bt_n  = 1'b1;
        end
      end
      PENDENTE: begin
        if (atende) begin
          if (HOLDOFF != 8'd0) begin
            est_n  = BLOQUEIO;
            hcnt_n = HOLDOFF - 8'd1;
          end else begin
            est_n = OCIOSO;
          end
        end
      end
      BLOQUEIO: begin
        if (hcnt_p2 == 8'd0) begin
          est_n = OCIOSO;
        end else begin
          hcnt_n = hcnt_p2 - 8'd1;
        end
      end
      default: est_n = OCIOSO;
    endcase
  end

  // stage p2: state and outputs registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      est_p2    <= OCIOSO;
      hcnt_p2   <= 8'd0;
      bt        <= 1'b0;
      pendente  <= 1'b0;
      bloqueado <= 1'b0;
    end else begin
      est_p2    <= est_n;
      hcnt_p2   <= hcnt_n;
      bt        <= bt_n;
      pendente  <= (est_n == PENDENTE);
      bloqueado <= (est_n == BLOQUEIO);
    end
  end

  assign estado = est_p2;

endmodule

// File: tb/tb_condicionador_botao.sv
// Directed bench for condicionador_botao (DEB_CYCLES=3, HOLDOFF=4, plus a
// HOLDOFF=0 instance); per-cycle expectations flow through a queue.
module tb_condicionador_botao;

  logic       clk = 1'b0;
  logic       rst;
  logic       bt_bruto, atende;
  logic       bt, pendente, bloqueado;
  logic [1:0] estado;
  logic       bt_bruto0, atende0;
  logic       bt0, pendente0, bloqueado0;
  logic [1:0] estado0;

  logic [4:0] q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  int n_pulse0 = 0;
  int p_base   = 0;
  logic bt_prev = 1'b0;

  always #5 clk = ~clk;

  condicionador_botao #(.DEB_CYCLES(8'd3), .HOLDOFF(8'd4)) dut (
    .clk(clk), .rst(rst), .bt_bruto(bt_bruto), .atende(atende),
    .bt(bt), .pendente(pendente), .bloqueado(bloqueado), .estado(estado)
  );

  condicionador_botao #(.DEB_CYCLES(8'd3), .HOLDOFF(8'd0)) dut_h0 (
    .clk(clk), .rst(rst), .bt_bruto(bt_bruto0), .atende(atende0),
    .bt(bt0), .pendente(pendente0), .bloqueado(bloqueado0), .estado(estado0)
  );

  task automatic run(input string tag, input int n, input logic b, input logic a,
                     input logic ebt, input logic epend, input logic ebloq,
                     input logic [1:0] eest);
    logic [4:0] exp_v, obs_v;
    for (int i = 0; i < n; i++) begin
      bt_bruto = b;
      atende   = a;
      q.push_back({ebt, epend, ebloq, eest});
      @(posedge clk);
      #1;
      exp_v = q.pop_front();
      obs_v = {bt, pendente, bloqueado, estado};
      n_assert++;
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s step %0d: {bt,pend,bloq,est} observed %b expected %b", tag, i, obs_v, exp_v);
      end
      n_assert++;
      assert (!(bt_prev && bt)) else begin
        n_fail++;
        $error("FAIL %s step %0d: bt high two cycles, observed 1 expected 0", tag, i);
      end
      bt_prev = bt;
      if (bt) n_pulse++;
    end
  endtask

  task automatic run0(input string tag, input int n, input logic b, input logic a,
                      input logic ebt, input logic epend, input logic ebloq,
                      input logic [1:0] eest);
    logic [4:0] exp_v, obs_v;
    for (int i = 0; i < n; i++) begin
      bt_bruto0 = b;
      atende0   = a;
      q.push_back({ebt, epend, ebloq, eest});
      @(posedge clk);
      #1;
      exp_v = q.pop_front();
      obs_v = {bt0, pendente0, bloqueado0, estado0};
      n_assert++;
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s step %0d: {bt,pend,bloq,est} observed %b expected %b", tag, i, obs_v, exp_v);
      end
      if (bt0) n_pulse0++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, observed no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bt_bruto = 1'b1; atende = 1'b0;
    bt_bruto0 = 1'b0; atende0 = 1'b0;

    // Reset with button held; held button counts as a fresh press afterwards.
    run("reset",      2, 1, 0, 0, 0, 0, 2'd0);
    rst = 1'b0;
    run("rst_deb",    4, 1, 0, 0, 0, 0, 2'd0);
    run("rst_pulse",  1, 1, 0, 1, 1, 0, 2'd1);
    run("rst_pend",   3, 1, 0, 0, 1, 0, 2'd1);

    // Acknowledge: four hold-off cycles, then idle; release button.
    run("ack",        1, 1, 1, 0, 0, 1, 2'd2);
    run("ack_bloq",   3, 1, 0, 0, 0, 1, 2'd2);
    run("ack_idle",   8, 0, 0, 0, 0, 0, 2'd0);

    // Bounce: runs of two samples never reach the threshold.
    run("bounce1",    2, 1, 0, 0, 0, 0, 2'd0);
    run("bounce0",    2, 0, 0, 0, 0, 0, 2'd0);
    run("bounce1b",   2, 1, 0, 0, 0, 0, 2'd0);
    run("bounce0b",   4, 0, 0, 0, 0, 0, 2'd0);
    run("bnc_hold",   4, 1, 0, 0, 0, 0, 2'd0);
    run("bnc_pulse",  1, 1, 0, 1, 1, 0, 2'd1);
    run("bnc_pend",   1, 1, 0, 0, 1, 0, 2'd1);

    // Simultaneous atende and second debounced rise while pending.
    run("sim_rel",    5, 0, 0, 0, 1, 0, 2'd1);
    run("sim_press",  4, 1, 0, 0, 1, 0, 2'd1);
    run("sim_ack",    1, 1, 1, 0, 0, 1, 2'd2);
    run("sim_bloq",   3, 1, 0, 0, 0, 1, 2'd2);
    run("sim_idle",  11, 1, 0, 0, 0, 0, 2'd0);

    // Hold-off discard: rise lands in the last BLOQUEIO cycle.
    run("hd_rel",     5, 0, 0, 0, 0, 0, 2'd0);
    run("hd_press",   4, 1, 0, 0, 0, 0, 2'd0);
    run("hd_pulse",   1, 1, 0, 1, 1, 0, 2'd1);
    run("hd_rel2",    5, 0, 0, 0, 1, 0, 2'd1);
    run("hd_ack",     1, 1, 1, 0, 0, 1, 2'd2);
    run("hd_bloq",    3, 1, 0, 0, 0, 1, 2'd2);
    run("hd_discard", 4, 1, 0, 0, 0, 0, 2'd0);
    run("hd_rel3",    5, 0, 0, 0, 0, 0, 2'd0);
    run("hd_press2",  4, 1, 0, 0, 0, 0, 2'd0);
    run("hd_pulse2",  1, 1, 0, 1, 1, 0, 2'd1);
    run("hd_pend2",   2, 1, 0, 0, 1, 0, 2'd1);

    // Reset mid-operation aborts the pending request; held 50 cycles -> 1 pulse.
    rst = 1'b1;
    run("rst2",       2, 1, 0, 0, 0, 0, 2'd0);
    rst = 1'b0;
    p_base = n_pulse;
    run("rst2_deb",   4, 1, 0, 0, 0, 0, 2'd0);
    run("rst2_pulse", 1, 1, 0, 1, 1, 0, 2'd1);
    run("hold50",    45, 1, 0, 0, 1, 0, 2'd1);
    n_assert++;
    assert ((n_pulse - p_base) == 1) else begin
      n_fail++;
      $error("FAIL hold50_pulses: observed %0d expected 1", n_pulse - p_base);
    end
    n_assert++;
    assert (n_pulse == 5) else begin
      n_fail++;
      $error("FAIL total_pulses: observed %0d expected 5", n_pulse);
    end

    // HOLDOFF = 0 instance: acknowledge returns straight to idle.
    run0("h0_deb",    4, 1, 0, 0, 0, 0, 2'd0);
    run0("h0_pulse",  1, 1, 0, 1, 1, 0, 2'd1);
    run0("h0_pend",   2, 1, 0, 0, 1, 0, 2'd1);
    run0("h0_ack",    1, 1, 1, 0, 0, 0, 2'd0);
    run0("h0_idle",   6, 1, 0, 0, 0, 0, 2'd0);
    n_assert++;
    assert (n_pulse0 == 1) else begin
      n_fail++;
      $error("FAIL h0_pulses: observed %0d expected 1", n_pulse0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
